// File: rtl/regfile_op_sequencer_if.sv
// Sequencer bus: instruction handshake, register-file control/data and status.
// master = sequencer side, slave = requester / register-file side.
interface regfile_op_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              start;
  logic [2:0]        op;
  logic [ADDR_W-1:0] rd;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] imm;
  logic              rf_we_n;
  logic              rf_oe_n;
  logic [ADDR_W-1:0] rf_waddr;
  logic [ADDR_W-1:0] rf_raddr0;
  logic [ADDR_W-1:0] rf_raddr1;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata0;
  logic [DATA_W-1:0] rf_rdata1;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              carry;
  logic              err;

  modport master (
    input  start, op, rd, rs, rt, imm, rf_rdata0, rf_rdata1,
    output rf_we_n, rf_oe_n, rf_waddr, rf_raddr0, rf_raddr1, rf_wdata,
           busy, done, result, zero, carry, err
  );

  modport slave (
    output start, op, rd, rs, rt, imm, rf_rdata0, rf_rdata1,
    input  rf_we_n, rf_oe_n, rf_waddr, rf_raddr0, rf_raddr1, rf_wdata,
           busy, done, result, zero, carry, err
  );
endinterface

// File: rtl/regfile_op_sequencer.sv
// Multi-cycle register-file execution controller: READ, LATCH, EXEC, WB, DONE.
// Define REGSEQ_MUL_EN to build the 16-cycle shift-add multiplier; otherwise op 111 flags err.
module regfile_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int SH_W   = 4
) (
  input logic                    clk,
  input logic                    rst,
  regfile_op_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LATCH, S_EXEC, S_WB, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_LDI = 3'b101, OP_SHL = 3'b110, OP_MUL = 3'b111
  } op_t;

`ifdef REGSEQ_MUL_EN
  localparam logic MUL_HW = 1'b1;
`else
  localparam logic MUL_HW = 1'b0;
`endif

  state_t            state, state_nx;
  op_t               op_q;
  logic [ADDR_W-1:0] rd_q, rs_q, rt_q;
  logic [DATA_W-1:0] imm_q, a_q, b_q, res_q, result_q;
  logic              cy_q, zero_q, carry_q, err_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cy;
  logic [DATA_W:0]   alu_wide;

`ifdef REGSEQ_MUL_EN
  // b_q doubles as the right-shifting multiplier during MUL.
  logic [SH_W-1:0]     cnt_q;
  logic [2*DATA_W-1:0] prod_q, mcand_q, prod_sum;
  logic                mul_last;

  assign mul_last = (cnt_q == SH_W'(DATA_W - 1));
  assign prod_sum = prod_q + (b_q[0] ? mcand_q : '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_READ;
      S_READ:  state_nx = S_LATCH;
      S_LATCH: state_nx = S_EXEC;
      S_EXEC: begin
        state_nx = S_WB;
        if (op_q == OP_MUL) begin
`ifdef REGSEQ_MUL_EN
          if (!mul_last) state_nx = S_EXEC;
`else
          state_nx = S_DONE;
`endif
        end
      end
      S_WB:    state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.rf_we_n   = 1'b1;
    bus.rf_oe_n   = 1'b1;
    bus.rf_waddr  = '0;
    bus.rf_raddr0 = '0;
    bus.rf_raddr1 = '0;
    bus.rf_wdata  = '0;
    bus.busy      = (state != S_IDLE);
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    case (state)
      S_READ, S_LATCH: begin
        bus.rf_oe_n   = 1'b0;
        bus.rf_raddr0 = rs_q;
        bus.rf_raddr1 = rt_q;
      end
      S_WB: begin
        bus.rf_we_n  = 1'b0;
        bus.rf_waddr = rd_q;
        bus.rf_wdata = res_q;
      end
      S_DONE: begin
        bus.done = 1'b1;
        bus.err  = err_q;
      end
      default: ;
    endcase
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.carry  = carry_q;

  // SHL carry comes out of bit DATA_W of the widened shift, which is 0 for a zero shift.
  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_cy   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_wide = {1'b0, a_q} + {1'b0, b_q};
        alu_res  = alu_wide[DATA_W-1:0];
        alu_cy   = alu_wide[DATA_W];
      end
      OP_SUB: begin
        alu_wide = {1'b0, a_q} - {1'b0, b_q};
        alu_res  = alu_wide[DATA_W-1:0];
        alu_cy   = alu_wide[DATA_W];
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_LDI: alu_res = imm_q;
      OP_SHL: begin
        alu_wide = {1'b0, a_q} << b_q[SH_W-1:0];
        alu_res  = alu_wide[DATA_W-1:0];
        alu_cy   = alu_wide[DATA_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_ADD;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cy_q     <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
`ifdef REGSEQ_MUL_EN
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          op_q  <= op_t'(bus.op);
          rd_q  <= bus.rd;
          rs_q  <= bus.rs;
          rt_q  <= bus.rt;
          imm_q <= bus.imm;
          err_q <= 1'b0;
        end
        S_LATCH: begin
          a_q <= bus.rf_rdata0;
          b_q <= bus.rf_rdata1;
`ifdef REGSEQ_MUL_EN
          cnt_q   <= '0;
          prod_q  <= '0;
          mcand_q <= {{DATA_W{1'b0}}, bus.rf_rdata0};
`endif
        end
        S_EXEC: begin
          err_q <= (op_q == OP_MUL) && !MUL_HW;
          if (op_q == OP_MUL) begin
`ifdef REGSEQ_MUL_EN
            prod_q  <= prod_sum;
            mcand_q <= mcand_q << 1;
            b_q     <= b_q >> 1;
            cnt_q   <= cnt_q + SH_W'(1);
            if (mul_last) begin
              res_q <= prod_sum[DATA_W-1:0];
              cy_q  <= |prod_sum[2*DATA_W-1:DATA_W];
            end
`endif
          end else begin
            res_q <= alu_res;
            cy_q  <= alu_cy;
          end
        end
        S_WB: begin
          result_q <= res_q;
          zero_q   <= (res_q == '0);
          carry_q  <= cy_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Scoreboard bench for regfile_op_sequencer with a behavioural 8x16 register file.
// Expectations follow REGSEQ_MUL_EN if the bench is built with it.
module tb_regfile_op_sequencer;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, LDI = 3'b101, SHL = 3'b110, MUL = 3'b111;
`ifdef REGSEQ_MUL_EN
  localparam logic MUL_HW = 1'b1;
`else
  localparam logic MUL_HW = 1'b0;
`endif

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        e;
    int          due;
    int          wb;
  } exp_t;

  logic        clk;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          we_seen = 0;
  int          overlap = 0;
  logic [15:0] mem [0:7] = '{default: 16'h0000};
  exp_t        sbq[$];
  string       nameq[$];
  exp_t        mon_e;
  string       mon_nm;

  regfile_op_sequencer_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  regfile_op_sequencer #(.DATA_W(16), .ADDR_W(3), .SH_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!bus.rf_we_n) mem[bus.rf_waddr] <= bus.rf_wdata;
  end

  assign bus.rf_rdata0 = bus.rf_oe_n ? 16'h0000 : mem[bus.rf_raddr0];
  assign bus.rf_rdata1 = bus.rf_oe_n ? 16'h0000 : mem[bus.rf_raddr1];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!bus.rf_we_n && !bus.rf_oe_n) overlap++;
    if (!bus.rf_we_n) we_seen++;
    if (bus.done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        mon_e  = sbq.pop_front();
        mon_nm = nameq.pop_front();
        chk({mon_nm, "_result"}, 32'(bus.result), 32'(mon_e.res));
        chk({mon_nm, "_zero"}, 32'(bus.zero), 32'(mon_e.z));
        chk({mon_nm, "_carry"}, 32'(bus.carry), 32'(mon_e.c));
        chk({mon_nm, "_err"}, 32'(bus.err), 32'(mon_e.e));
        chk({mon_nm, "_latency"}, 32'(cyc), 32'(mon_e.due));
        chk({mon_nm, "_writes"}, 32'(we_seen), 32'(mon_e.wb));
      end
      we_seen = 0;
    end
  end

  task automatic launch(input string nm, input logic [2:0] o, input int d, input int s,
                        input int t, input logic [15:0] im, input logic [15:0] r,
                        input logic z, input logic c, input bit push);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.rd    = 3'(d);
    bus.rs    = 3'(s);
    bus.rt    = 3'(t);
    bus.imm   = im;
    e.res = r;
    e.z   = z;
    e.c   = c;
    e.e   = (o == MUL) && !MUL_HW;
    e.wb  = e.e ? 0 : 1;
    e.due = cyc + 1 + ((o == MUL) ? (MUL_HW ? 19 : 3) : 4);
    if (push) begin
      sbq.push_back(e);
      nameq.push_back(nm);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
      nameq.delete();
    end
  endtask

  task automatic run(input string nm, input logic [2:0] o, input int d, input int s,
                     input int t, input logic [15:0] im, input logic [15:0] r,
                     input logic z, input logic c);
    launch(nm, o, d, s, t, im, r, z, c, 1'b1);
    wait_idle();
  endtask

  initial begin
    exp_t e1, e2;
    int   k, n;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.rd    = 3'd0;
    bus.rs    = 3'd0;
    bus.rt    = 3'd0;
    bus.imm   = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_we_n", 32'(bus.rf_we_n), 32'd1);
    chk("rst_oe_n", 32'(bus.rf_oe_n), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flags", 32'({bus.zero, bus.carry, bus.err}), 32'd0);
    chk("rst_addr", 32'({bus.rf_waddr, bus.rf_raddr0, bus.rf_raddr1}), 32'd0);
    chk("rst_wdata", 32'(bus.rf_wdata), 32'd0);
    rst = 1'b0;

    run("ldi_r1", LDI, 1, 0, 0, 16'h1234, 16'h1234, 1'b0, 1'b0);
    run("ldi_r2", LDI, 2, 0, 0, 16'h00FF, 16'h00FF, 1'b0, 1'b0);
    chk("r1_ldi", 32'(mem[1]), 32'h1234);
    chk("r2_ldi", 32'(mem[2]), 32'h00FF);

    run("ldi_ffff", LDI, 1, 0, 0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    run("ldi_0001", LDI, 2, 0, 0, 16'h0001, 16'h0001, 1'b0, 1'b0);
    run("add_wrap", ADD, 3, 1, 2, 16'h0000, 16'h0000, 1'b1, 1'b1);
    chk("r3_add", 32'(mem[3]), 32'h0000);
    run("sub_borrow", SUB, 4, 2, 1, 16'h0000, 16'h0002, 1'b0, 1'b1);
    chk("r4_sub", 32'(mem[4]), 32'h0002);

    run("ldi_8001", LDI, 1, 0, 0, 16'h8001, 16'h8001, 1'b0, 1'b0);
    run("shl_1", SHL, 5, 1, 2, 16'h0000, 16'h0002, 1'b0, 1'b1);
    chk("r5_shl1", 32'(mem[5]), 32'h0002);
    run("ldi_0010", LDI, 2, 0, 0, 16'h0010, 16'h0010, 1'b0, 1'b0);
    run("shl_0", SHL, 5, 1, 2, 16'h0000, 16'h8001, 1'b0, 1'b0);
    chk("r5_shl0", 32'(mem[5]), 32'h8001);

    run("ldi_f0f0", LDI, 1, 0, 0, 16'hF0F0, 16'hF0F0, 1'b0, 1'b0);
    run("ldi_ff00", LDI, 2, 0, 0, 16'hFF00, 16'hFF00, 1'b0, 1'b0);
    run("and", AND_, 3, 1, 2, 16'h0000, 16'hF000, 1'b0, 1'b0);
    run("or", OR_, 3, 1, 2, 16'h0000, 16'hFFF0, 1'b0, 1'b0);

    // start pulsed while busy must be ignored (would write r7)
    launch("xor", XOR_, 3, 1, 2, 16'h0000, 16'h0FF0, 1'b0, 1'b0, 1'b1);
    bus.start = 1'b1;
    bus.op    = LDI;
    bus.rd    = 3'd7;
    bus.imm   = 16'hBEEF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    chk("r3_xor", 32'(mem[3]), 32'h0FF0);
    repeat (8) @(negedge clk);
    chk("r7_untouched", 32'(mem[7]), 32'h0000);

    run("ldi_0100a", LDI, 1, 0, 0, 16'h0100, 16'h0100, 1'b0, 1'b0);
    run("ldi_0100b", LDI, 2, 0, 0, 16'h0100, 16'h0100, 1'b0, 1'b0);
    run("ldi_7777", LDI, 6, 0, 0, 16'h7777, 16'h7777, 1'b0, 1'b0);
    run("mul", MUL, 6, 1, 2, 16'h0000, MUL_HW ? 16'h0000 : 16'h7777, MUL_HW, MUL_HW);
    chk("r6_mul", 32'(mem[6]), MUL_HW ? 32'h0000 : 32'h7777);

    // reset during EXEC of an ADD into r4
    launch("add_rst", ADD, 4, 1, 2, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_we_n", 32'(bus.rf_we_n), 32'd1);
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_flags", 32'({bus.zero, bus.carry}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("r4_kept", 32'(mem[4]), 32'h0002);

    // back-to-back: start held across DONE
    @(negedge clk);
    k = cyc;
    bus.start = 1'b1;
    bus.op    = LDI;
    bus.rd    = 3'd1;
    bus.imm   = 16'h0003;
    e1.res = 16'h0003; e1.z = 1'b0; e1.c = 1'b0; e1.e = 1'b0; e1.due = k + 5;  e1.wb = 1;
    e2.res = 16'h0006; e2.z = 1'b0; e2.c = 1'b0; e2.e = 1'b0; e2.due = k + 11; e2.wb = 1;
    sbq.push_back(e1);
    nameq.push_back("b2b_ldi");
    sbq.push_back(e2);
    nameq.push_back("b2b_add");
    @(negedge clk);
    bus.op = ADD;
    bus.rd = 3'd1;
    bus.rs = 3'd1;
    bus.rt = 3'd1;
    n = 0;
    while (sbq.size() > 1 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("b2b_first_done", 32'(sbq.size()), 32'd1);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    chk("r1_b2b", 32'(mem[1]), 32'h0006);

    repeat (4) @(negedge clk);
    chk("we_oe_overlap", 32'(overlap), 32'd0);
    chk("queue_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
